// File: rtl/btn_press_classifier_if.sv
// Bundles the button levels and the classified pulse outputs of btn_press_classifier.
// master drives the buttons and observes the pulses; slave is the classifier itself.
interface btn_press_classifier_if;
  logic [3:0] i_btn;
  logic [3:0] o_short;
  logic [3:0] o_long;
  logic [3:0] o_rep;
  logic [3:0] o_held;

  modport master (output i_btn, input o_short, o_long, o_rep, o_held);
  modport slave  (input i_btn, output o_short, o_long, o_rep, o_held);
endinterface

// File: rtl/btn_press_classifier.sv
// Four independent short / long / auto-repeat press classifiers with registered one-cycle pulses.
// Define BTN_AUTOREPEAT_EN to enable o_rep pulses every REPEAT_CYC samples while a button is held.
module btn_press_classifier #(
  parameter int LONG_CYC   = 100_000_000,
  parameter int REPEAT_CYC = 20_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  btn_press_classifier_if.slave  bus
);

  // Width covers both periods so the build option never changes counter sizing.
  localparam int MAX_CYC = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2
  } state_t;

  logic [3:0] w_short;
  logic [3:0] w_long;
  logic [3:0] w_held;
`ifdef BTN_AUTOREPEAT_EN
  logic [3:0] w_rep;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      state_t           r_state;
      logic [CNT_W-1:0] r_cnt;
      logic             r_short;
      logic             r_long;
      logic             r_held;
`ifdef BTN_AUTOREPEAT_EN
      logic             r_rep;
`endif

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_state <= IDLE;
          r_cnt   <= '0;
          r_short <= 1'b0;
          r_long  <= 1'b0;
          r_held  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          r_rep   <= 1'b0;
`endif
        end else begin
          r_short <= 1'b0;
          r_long  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
          r_rep   <= 1'b0;
`endif
          case (r_state)
            IDLE: begin
              if (bus.i_btn[gi]) begin
                r_state <= PRESS;
                r_cnt   <= CNT_W'(1);
              end
            end
            PRESS: begin
              if (!bus.i_btn[gi]) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_short <= 1'b1;
              end else if (r_cnt == LONG_LAST) begin
                r_state <= HOLD;
                r_cnt   <= '0;
                r_long  <= 1'b1;
                r_held  <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
            HOLD: begin
              if (!bus.i_btn[gi]) begin
                r_state <= IDLE;
                r_cnt   <= '0;
                r_held  <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
              end else if (r_cnt == REP_LAST) begin
                r_cnt <= '0;
                r_rep <= 1'b1;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
`endif
              end
            end
            default: begin
              r_state <= IDLE;
              r_cnt   <= '0;
              r_held  <= 1'b0;
            end
          endcase
        end
      end

      assign w_short[gi] = r_short;
      assign w_long[gi]  = r_long;
      assign w_held[gi]  = r_held;
`ifdef BTN_AUTOREPEAT_EN
      assign w_rep[gi]   = r_rep;
`endif
    end
  endgenerate

  assign bus.o_short = w_short;
  assign bus.o_long  = w_long;
  assign bus.o_held  = w_held;
`ifdef BTN_AUTOREPEAT_EN
  assign bus.o_rep   = w_rep;
`else
  assign bus.o_rep   = 4'b0000;
`endif

endmodule

// File: tb/tb_btn_press_classifier.sv
// Randomized plus directed bench for btn_press_classifier with LONG_CYC=10, REPEAT_CYC=4.
// Expected outputs come from a run-length model of each button pushed into a scoreboard queue.
module tb_btn_press_classifier;
  localparam int LONG_CYC   = 10;
  localparam int REPEAT_CYC = 4;

  logic clk;
  logic rst;
  btn_press_classifier_if bus ();

  btn_press_classifier #(
    .LONG_CYC   (LONG_CYC),
    .REPEAT_CYC (REPEAT_CYC)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int run_len [4];
  logic [15:0] sb_q [$];   // {short, long, rep, held}

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got short=%b long=%b rep=%b held=%b, required short=%b long=%b rep=%b held=%b",
               name, act[15:12], act[11:8], act[7:4], act[3:0],
               exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  // Run-length reference: outputs after an edge depend only on how many consecutive
  // high samples each button has accumulated.
  task automatic push_expected(input logic [3:0] b);
    logic [3:0] e_short, e_long, e_rep, e_held;
    e_short = '0; e_long = '0; e_rep = '0; e_held = '0;
    for (int k = 0; k < 4; k++) begin
      if (b[k]) begin
        run_len[k]++;
        if (run_len[k] == LONG_CYC) e_long[k] = 1'b1;
        if (run_len[k] >= LONG_CYC) e_held[k] = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
        if (run_len[k] > LONG_CYC && ((run_len[k] - LONG_CYC) % REPEAT_CYC) == 0)
          e_rep[k] = 1'b1;
`endif
      end else begin
        if (run_len[k] > 0 && run_len[k] < LONG_CYC) e_short[k] = 1'b1;
        run_len[k] = 0;
      end
    end
    sb_q.push_back({e_short, e_long, e_rep, e_held});
  endtask

  task automatic step(input logic [3:0] b);
    bus.i_btn = b;
    @(posedge clk);
    push_expected(b);
    #1;
  endtask

  task automatic hold_then_release(input logic [3:0] b, input int n_high, input int n_low);
    for (int i = 0; i < n_high; i++) step(b);
    for (int i = 0; i < n_low; i++) step(4'b0000);
  endtask

  function automatic logic [15:0] outs();
    return {bus.o_short, bus.o_long, bus.o_rep, bus.o_held};
  endfunction

  // Monitor: one expected entry per clock edge, checked on the following falling edge.
  int mon_cycle = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        logic [15:0] exp;
        exp = sb_q.pop_front();
        mon_cycle++;
        check16($sformatf("cycle%0d", mon_cycle), outs(), exp);
      end
    end
  end

  initial begin
    int remain [4];
    logic [3:0] lvl;
    int waited;

    rst = 1'b0;
    bus.i_btn = 4'b0000;
    for (int k = 0; k < 4; k++) run_len[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check16("reset_state", outs(), 16'h0000);
    bus.i_btn = 4'b0101;
    @(posedge clk);
    #1;
    check16("reset_ignores_btn", outs(), 16'h0000);
    bus.i_btn = 4'b0000;
    rst = 1'b1;

    hold_then_release(4'b0000, 0, 50);    // idle
    hold_then_release(4'b0001, 3, 4);     // short on bit 0
    hold_then_release(4'b0100, 9, 4);     // just below threshold
    hold_then_release(4'b0100, 10, 4);    // exactly the threshold
    hold_then_release(4'b0010, 22, 4);    // long plus repeats
    hold_then_release(4'b1111, 5, 4);     // all four together
    hold_then_release(4'b1000, 1, 4);     // single-cycle press

    // Reset during sample 6 of a held press, button stays high across release.
    for (int i = 0; i < 5; i++) step(4'b1000);
    @(negedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) run_len[k] = 0;
    #1;
    check16("reset_mid_press", outs(), 16'h0000);
    @(posedge clk);
    #1;
    check16("reset_held_edge", outs(), 16'h0000);
    rst = 1'b1;
    hold_then_release(4'b1000, 12, 4);

    // Random per-button run lengths spanning short, long and repeat regions.
    lvl = 4'b0000;
    for (int k = 0; k < 4; k++) remain[k] = $urandom_range(1, 6);
    for (int c = 0; c < 800; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (remain[k] == 0) begin
          lvl[k] = ~lvl[k];
          remain[k] = lvl[k] ? $urandom_range(1, 24) : $urandom_range(1, 5);
        end
        remain[k]--;
      end
      step(lvl);
    end
    hold_then_release(4'b0000, 0, 4);

    waited = 0;
    while (sb_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    #1;
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, required 0", sb_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/btn_press_classifier.md
BTN_PRESS_CLASSIFIER -- requirements
Module: btn_press_classifier

Interface
REQ-001 Parameter LONG_CYC, default 100_000_000, SHALL be the number of consecutive high samples that make a long press (legal range 2..2^31-1).
REQ-002 Parameter REPEAT_CYC, default 20_000_000, SHALL be the auto-repeat period in cycles while held (legal range 1..2^31-1).
REQ-003 clk  input  1  SHALL be the single system clock; all logic uses its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_btn  input  4  SHALL carry the debounced, clk-synchronous, active-high button levels.
REQ-006 o_short  output  4  SHALL carry a one-cycle pulse per button on short-press release.
REQ-007 o_long  output  4  SHALL carry a one-cycle pulse per button when the long-press threshold is reached.
REQ-008 o_rep  output  4  SHALL carry a one-cycle auto-repeat pulse per button while held.
REQ-009 o_held  output  4  SHALL be high per button while that button is in the HOLD state.

Function
REQ-010 Each of the four bits SHALL have an independent FSM and cycle counter; no bit affects another.
REQ-011 The FSM states SHALL be IDLE, PRESS and HOLD.
REQ-012 IDLE: i_btn sampled 1 -> PRESS with counter = 1; otherwise stay in IDLE.
REQ-013 PRESS: i_btn sampled 0 -> IDLE and o_short = 1 for exactly the next cycle.
REQ-014 PRESS: i_btn sampled 1 with counter = LONG_CYC-1 -> HOLD, counter = 0, o_long = 1 for exactly the next cycle; otherwise counter increments.
REQ-015 Net timing: N consecutive high samples with N < LONG_CYC SHALL give one o_short pulse, registered, in the cycle after the first low sample.
REQ-016 Net timing: N >= LONG_CYC SHALL give one o_long pulse in the cycle after the LONG_CYC-th high sample, and no o_short pulse.
REQ-017 HOLD: i_btn sampled 0 -> IDLE, with no release pulse.
REQ-018 o_held SHALL be registered, asserting in the same cycle as o_long and deasserting in the cycle after the first low sample.
REQ-019 All outputs SHALL be registered, with no combinational path from i_btn.
REQ-020 Counter width SHALL be $clog2 of the larger of LONG_CYC and REPEAT_CYC, minimum 1 bit; the counter SHALL never wrap within a state.
REQ-021 Multiple bits of any output MAY assert in the same cycle.
REQ-022 A one-cycle high pulse on i_btn SHALL produce an o_short pulse.

Reset
REQ-023 While rst = 0, all FSMs SHALL be in IDLE, all counters SHALL be 0, and o_short, o_long, o_rep and o_held SHALL all be 4'b0000.
REQ-024 Reset asserted mid-press SHALL discard the press without emitting any pulse.
REQ-025 A button already high when rst is released SHALL count as a new press, starting from the first high sample after release.

Configuration
REQ-026 Macro BTN_AUTOREPEAT_EN, when defined, SHALL make HOLD count cycles and pulse o_rep for one cycle after every REPEAT_CYC further high samples, then clear the counter.
REQ-027 The first o_rep pulse SHALL occur REPEAT_CYC cycles after the o_long pulse.
REQ-028 Without BTN_AUTOREPEAT_EN, o_rep SHALL be tied to 4'b0000, the HOLD counter logic SHALL be absent, and REPEAT_CYC SHALL be ignored.

Verification (LONG_CYC=10, REPEAT_CYC=4)
REQ-029 Bench SHALL check: reset released, i_btn = 0 for 50 cycles -> all outputs remain 0.
REQ-030 Bench SHALL check: i_btn[0] high for 3 cycles, then low -> o_short = 4'b0001 for one cycle, in the cycle after the first low sample; o_long and o_held stay 0.
REQ-031 Bench SHALL check: i_btn[2] high for 9 cycles -> o_short[2] pulse only.
REQ-032 Bench SHALL check: i_btn[2] high for 10 cycles -> o_long[2] pulse after the 10th sample, o_held[2] high, and no o_short pulse.
REQ-033 Bench SHALL check, with BTN_AUTOREPEAT_EN: i_btn[1] high for 22 cycles -> o_long[1] after sample 10 and o_rep[1] after samples 14, 18 and 22; without the macro, no o_rep pulses occur.
REQ-034 Bench SHALL check: i_btn = 4'b1111 high for 5 cycles, then low -> o_short = 4'b1111 in a single cycle.
REQ-035 Bench SHALL check: rst pulsed low during sample 6 of a press with i_btn held high -> no pulse from that press, and o_long occurs 10 samples after rst is released.
